// File: rtl/qosc_pkg.sv
// Shared definitions for the oscillator register bank and its SPI loader:
// register addresses, frame geometry and the loader state encoding.
package qosc_pkg;

   localparam int FRAME_BITS  = 16;
   localparam int HEADER_BITS = 8;

   localparam logic [2:0] ADDR_ID       = 3'd0;
   localparam logic [2:0] ADDR_INIT_RE  = 3'd2;
   localparam logic [2:0] ADDR_INIT_IM  = 3'd3;
   localparam logic [2:0] ADDR_RE_COEFF = 3'd4;
   localparam logic [2:0] ADDR_IM_COEFF = 3'd5;
   localparam logic [2:0] ADDR_POWER    = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_COMMIT,
      ST_DONE
   } spi_state_e;

endpackage

// File: rtl/spi_reg_loader_if.sv
// SPI pin bundle between an off-chip master and the register loader.
interface spi_reg_loader_if;

   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs_n, output mosi, input miso);
   modport slave  (input sclk, input cs_n, input mosi, output miso);

endinterface

// File: rtl/spi_reg_loader_sync_edge.sv
// 2-FF synchroniser for an asynchronous pin, plus single-cycle rise/fall pulses
// derived from the synchronised level and a one-cycle delayed copy.
module sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         dly_q  <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that turns 16-bit frames into register-bank write strobes.
// Define SPI_REG_LOADER_READBACK_EN to enable read frames returning data on miso.
module spi_reg_loader
   import qosc_pkg::*;
#(
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   spi_reg_loader_if.slave        spi,
   input  logic [7:0]             rd_init_re,
   input  logic [7:0]             rd_init_im,
   input  logic [7:0]             rd_re_coeff,
   input  logic [7:0]             rd_im_coeff,
   input  logic [7:0]             rd_power,
   output logic                   load,
   output logic [2:0]             address,
   output logic [7:0]             data_out,
   output logic                   busy
);

   // Index 0 is sclk (idles low), index 1 is cs_n (idles high).
   localparam logic [1:0] SYNC_RESET = 2'b10;

   logic [1:0] pin_raw;
   logic [1:0] pin_lvl;
   logic [1:0] pin_rise;
   logic [1:0] pin_fall;

   assign pin_raw = {spi.cs_n, spi.sclk};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge #(
         .RESET_VAL (SYNC_RESET[gi])
      ) u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .d_i     (pin_raw[gi]),
         .sync_o  (pin_lvl[gi]),
         .rise_o  (pin_rise[gi]),
         .fall_o  (pin_fall[gi])
      );
   end

   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;

   assign sclk_rise = pin_rise[0];
   assign sclk_fall = pin_fall[0];
   assign cs_rise   = pin_rise[1];
   assign cs_fall   = pin_fall[1];

   logic mosi_meta_q;
   logic mosi_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mosi_meta_q <= 1'b0;
         mosi_q      <= 1'b0;
      end else begin
         mosi_meta_q <= spi.mosi;
         mosi_q      <= mosi_meta_q;
      end
   end

   spi_state_e state_q;
   logic [3:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic       rw_q;
   logic [2:0] hdr_addr_q;
   logic       load_q;
   logic [2:0] address_q;
   logic [7:0] data_out_q;
   logic       miso_q;

`ifdef SPI_REG_LOADER_READBACK_EN
   logic [7:0] rb_shift_q;
   logic [7:0] rb_value_d;
   logic       unused_ok;

   // Address bits sit at shift_q[5:3] at the moment the 8th header bit arrives.
   always_comb begin
      rb_value_d = 8'h00;
      case (shift_q[5:3])
         ADDR_ID:       rb_value_d = ID_VALUE;
         ADDR_INIT_RE:  rb_value_d = rd_init_re;
         ADDR_INIT_IM:  rb_value_d = rd_init_im;
         ADDR_RE_COEFF: rb_value_d = rd_re_coeff;
         ADDR_IM_COEFF: rb_value_d = rd_im_coeff;
         ADDR_POWER:    rb_value_d = rd_power;
         default:       rb_value_d = 8'h00;
      endcase
   end

   assign unused_ok = pin_lvl[0];
`else
   logic unused_ok;
   assign unused_ok = ^{pin_lvl[0], sclk_fall, ID_VALUE, rd_init_re, rd_init_im,
                        rd_re_coeff, rd_im_coeff, rd_power};
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         hdr_addr_q <= 3'd0;
         load_q     <= 1'b0;
         address_q  <= 3'd0;
         data_out_q <= 8'h00;
         miso_q     <= 1'b0;
`ifdef SPI_REG_LOADER_READBACK_EN
         rb_shift_q <= 8'h00;
`endif
      end else begin
         load_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_cnt_q <= 4'd0;
                  shift_q   <= 8'h00;
                  state_q   <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (cs_rise) begin
                  state_q <= ST_IDLE;
               end else if (sclk_rise) begin
                  shift_q   <= {shift_q[6:0], mosi_q};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'(HEADER_BITS - 1)) begin
                     rw_q       <= shift_q[6];
                     hdr_addr_q <= shift_q[5:3];
                     state_q    <= ST_DATA;
`ifdef SPI_REG_LOADER_READBACK_EN
                     rb_shift_q <= rb_value_d;
`endif
                  end
               end
            end
            ST_DATA: begin
               if (cs_rise) begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
               end else begin
                  if (sclk_rise) begin
                     shift_q   <= {shift_q[6:0], mosi_q};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        state_q <= ST_COMMIT;
                     end
                  end
`ifdef SPI_REG_LOADER_READBACK_EN
                  if (sclk_fall && rw_q) begin
                     miso_q     <= rb_shift_q[7];
                     rb_shift_q <= {rb_shift_q[6:0], 1'b0};
                  end
`endif
               end
            end
            ST_COMMIT: begin
               if (cs_rise) begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
               end else begin
                  if (!rw_q) begin
                     load_q     <= 1'b1;
                     address_q  <= hdr_addr_q;
                     data_out_q <= shift_q;
                  end
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (cs_rise) begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign spi.miso = miso_q;
   assign load     = load_q;
   assign address  = address_q;
   assign data_out = data_out_q;
   assign busy     = ~pin_lvl[1];

endmodule

// File: tb/tb_spi_reg_loader.sv
// Randomised frame-level bench for spi_reg_loader with a cycle-checked reference model.
module tb_spi_reg_loader;

`ifdef SPI_REG_LOADER_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rd_init_re, rd_init_im, rd_re_coeff, rd_im_coeff, rd_power;
   logic       load;
   logic [2:0] address;
   logic [7:0] data_out;
   logic       busy;

   spi_reg_loader_if spi ();

   spi_reg_loader #(
      .ID_VALUE (8'hA5)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi         (spi),
      .rd_init_re  (rd_init_re),
      .rd_init_im  (rd_init_im),
      .rd_re_coeff (rd_re_coeff),
      .rd_im_coeff (rd_im_coeff),
      .rd_power    (rd_power),
      .load        (load),
      .address     (address),
      .data_out    (data_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int loads_seen = 0;

   // Pin/reset history sampled at each rising clock edge.
   logic cs_p1 = 1'b1, cs_p2 = 1'b1, rst_p1 = 1'b1, rst_p2 = 1'b1;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      cs_p1  <= spi.cs_n;
      cs_p2  <= cs_p1;
      rst_p1 <= !reset_n;
      rst_p2 <= rst_p1;
   end

   typedef struct {
      int         due;
      logic [2:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] model_addr = 3'd0;
   logic [7:0] model_data = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] rb_value(input logic [2:0] a);
      logic [7:0] tbl [8];
      tbl = '{8'hA5, 8'h00, rd_init_re, rd_init_im, rd_re_coeff, rd_im_coeff, rd_power, 8'h00};
      return tbl[a];
   endfunction

   // Value the master must see on miso at rising sclk edge j (1-based).
   function automatic logic miso_exp(input logic [15:0] f, input int j);
      logic [7:0] v;
      v = rb_value(f[14:12]);
      if (RB_EN && f[15] && j > 8 && j <= 16) return v[16-j];
      return 1'b0;
   endfunction

   // Per-cycle compare of load/address/data_out/busy against the model.
   initial begin
      logic exp_load;
      logic exp_busy;
      forever begin
         @(negedge clk);
         exp_load = 1'b0;
         if (rst_p1) begin
            model_addr = 3'd0;
            model_data = 8'h00;
         end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_load   = 1'b1;
            model_addr = exp_q[0].a;
            model_data = exp_q[0].d;
            void'(exp_q.pop_front());
         end
         exp_busy = (rst_p1 || rst_p2) ? 1'b0 : !cs_p2;
         if (load === 1'b1) loads_seen++;
         check("load", load, exp_load);
         check("address", address, model_addr);
         check("data_out", data_out, model_data);
         check("busy", busy, exp_busy);
      end
   end

   task automatic spi_frame(input logic [15:0] frame, input int npulses, input int half,
                            input bit rst_at12, output logic [7:0] rx);
      int l0;
      l0 = loads_seen;
      rx = 8'h00;
      @(negedge clk);
      spi.sclk = 1'b0;
      spi.cs_n = 1'b0;
      spi.mosi = frame[15];
      repeat (4 + half) @(negedge clk);
      for (int i = 0; i < npulses; i++) begin
         if (i < 16) check("miso_bit", spi.miso, miso_exp(frame, i + 1));
         if (i >= 8 && i < 16) rx = {rx[6:0], spi.miso};
         spi.sclk = 1'b1;
         if (i == 15 && !frame[15] && !rst_at12)
            exp_q.push_back('{due: cyc + 4, a: frame[14:12], d: frame[7:0]});
         repeat (half) @(negedge clk);
         spi.sclk = 1'b0;
         if (i < 15) spi.mosi = frame[14-i];
         else        spi.mosi = 1'($urandom_range(0, 1));
         if (rst_at12 && i == 11) begin
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
            check("rst_load", load, 1'b0);
            check("rst_address", address, 3'd0);
            check("rst_data_out", data_out, 8'h00);
            check("rst_miso", spi.miso, 1'b0);
            check("rst_busy", busy, 1'b0);
            reset_n = 1'b1;
         end
         repeat (half) @(negedge clk);
      end
      spi.cs_n = 1'b1;
      repeat (8) @(negedge clk);
      check("idle_miso", spi.miso, 1'b0);
      $display("[TB] frame %04h pulses %0d half %0d rst %0d -> loads %0d rx %02h addr %0d data %02h",
               frame, npulses, half, rst_at12, loads_seen - l0, rx, address, data_out);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  rx;
      logic [15:0] f;
      int          l0, np, hp;

      spi.sclk    = 1'b0;
      spi.cs_n    = 1'b1;
      spi.mosi    = 1'b0;
      rd_init_re  = 8'h3C;
      rd_init_im  = 8'hC3;
      rd_re_coeff = 8'h5A;
      rd_im_coeff = 8'hA6;
      rd_power    = 8'h77;
      reset_n     = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_load", load, 1'b0);
      check("reset_address", address, 3'd0);
      check("reset_data_out", data_out, 8'h00);
      check("reset_miso", spi.miso, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      l0 = loads_seen;
      spi_frame(16'h4055, 16, 4, 1'b0, rx);
      check("w4055_loads", loads_seen - l0, 1);
      check("w4055_address", address, 3'd4);
      check("w4055_data", data_out, 8'h55);
      check("w4055_busy_after", busy, 1'b0);

      rd_power = 8'h10;
      l0 = loads_seen;
      spi_frame(16'hE000, 16, 4, 1'b0, rx);
      check("rd6_value", rx, RB_EN ? 8'h10 : 8'h00);
      check("rd6_loads", loads_seen - l0, 0);

      spi_frame(16'h8000, 16, 4, 1'b0, rx);
      check("rd0_value", rx, RB_EN ? 8'hA5 : 8'h00);
      spi_frame(16'hF000, 16, 4, 1'b0, rx);
      check("rd7_value", rx, 8'h00);
      check("rd_keeps_address", address, 3'd4);

      l0 = loads_seen;
      spi_frame(16'h41AB, 10, 4, 1'b0, rx);
      check("abort_loads", loads_seen - l0, 0);
      spi_frame(16'h2020, 16, 4, 1'b0, rx);
      check("after_abort_loads", loads_seen - l0, 1);
      check("after_abort_address", address, 3'd2);
      check("after_abort_data", data_out, 8'h20);

      l0 = loads_seen;
      spi_frame(16'h5099, 20, 4, 1'b0, rx);
      check("extra_loads", loads_seen - l0, 1);
      check("extra_address", address, 3'd5);
      check("extra_data", data_out, 8'h99);

      l0 = loads_seen;
      spi_frame(16'h3077, 16, 4, 1'b1, rx);
      check("midreset_loads", loads_seen - l0, 0);
      spi_frame(16'h6042, 16, 4, 1'b0, rx);
      check("post_reset_loads", loads_seen - l0, 1);
      check("post_reset_address", address, 3'd6);
      check("post_reset_data", data_out, 8'h42);

      for (int n = 0; n < 40; n++) begin
         rd_init_re  = 8'($urandom);
         rd_init_im  = 8'($urandom);
         rd_re_coeff = 8'($urandom);
         rd_im_coeff = 8'($urandom);
         rd_power    = 8'($urandom);
         f  = 16'($urandom);
         hp = $urandom_range(3, 5);
         case ($urandom_range(0, 4))
            0:       np = $urandom_range(1, 15);
            1:       np = $urandom_range(17, 20);
            default: np = 16;
         endcase
         spi_frame(f, np, hp, 1'b0, rx);
      end

      repeat (10) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
